// File: rtl/button_pkg.sv
// Shared types and default constants for the button debouncer.
package button_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } btn_state_t;

  // 1 ms and 1 s at 100 MHz.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 100000;
  localparam int unsigned LONG_CYCLES_DEF     = 100000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, reset value selectable.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Button debouncer: 2FF sync, 4-state acceptance FSM, edge pulses and an
// optional long-press pulse enabled with BUTTON_LONG_PRESS_EN.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit          ACTIVE_LOW      = 1'b0,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic long_press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic       pad_c;
  logic       sync_c;
  btn_state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic       level_q;
  logic       rise_q;
  logic       fall_q;

  // Inversion happens before the synchronizer so reset value 0 means released.
  assign pad_c = btn_in ^ logic'(ACTIVE_LOW);

  sync_2ff #(
    .RST_VAL (1'b0)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (pad_c),
    .q_o   (sync_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        STABLE_LO: begin
          if (sync_c) begin
            state_q <= PEND_HI;
            cnt_q   <= '0;
          end
        end
        PEND_HI: begin
          if (!sync_c) begin
            state_q <= STABLE_LO;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_HI;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!sync_c) begin
            state_q <= PEND_LO;
            cnt_q   <= '0;
          end
        end
        PEND_LO: begin
          if (sync_c) begin
            state_q <= STABLE_HI;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_LO;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= STABLE_LO;
      endcase
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;

`ifdef BUTTON_LONG_PRESS_EN
  localparam int unsigned LP_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES + 1) : 1;
  localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONG_CYCLES);

  logic            enter_hi_c;
  logic            exit_hi_c;
  logic            pressed_c;
  logic [LP_W-1:0] lp_cnt_d;
  logic [LP_W-1:0] lp_cnt_q;
  logic            long_q;

  assign enter_hi_c = (state_q == PEND_HI) && sync_c && (cnt_q == CNT_LAST);
  assign exit_hi_c  = (state_q == PEND_LO) && !sync_c && (cnt_q == CNT_LAST);
  assign pressed_c  = (state_q == STABLE_HI) || (state_q == PEND_LO);

  // Glitches in PEND_LO keep counting so a single press fires at most once.
  always_comb begin
    lp_cnt_d = lp_cnt_q;
    if (enter_hi_c || exit_hi_c || !pressed_c) begin
      lp_cnt_d = '0;
    end else if (lp_cnt_q != LP_MAX) begin
      lp_cnt_d = lp_cnt_q + LP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lp_cnt_q <= '0;
      long_q   <= 1'b0;
    end else begin
      lp_cnt_q <= lp_cnt_d;
      long_q   <= (lp_cnt_d == LP_MAX) && (lp_cnt_q != LP_MAX);
    end
  end

  assign long_press = long_q;
`else
  logic unused_long_c;
  assign unused_long_c = ^LONG_CYCLES;
  assign long_press    = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce (DEBOUNCE_CYCLES=4, LONG_CYCLES=20).
module tb_button_debounce;
  import button_pkg::*;

  typedef struct {
    int kind;   // 0 rise, 1 fall, 2 long
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;
  logic long_press;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];

  button_debounce #(
    .DEBOUNCE_CYCLES (4),
    .ACTIVE_LOW      (1'b0),
    .LONG_CYCLES     (20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_rise   (btn_rise),
    .btn_fall   (btn_fall),
    .long_press (long_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check_eq({name, "_level"}, int'(btn_level), 0);
    check_eq({name, "_rise"},  int'(btn_rise),  0);
    check_eq({name, "_fall"},  int'(btn_fall),  0);
    check_eq({name, "_long"},  int'(long_press), 0);
  endtask

  task automatic push_ev(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every output pulse must match the next expected event.
  task automatic pop_check(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_pulse kind=%0d at cycle %0d: got pulse, expected none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        errors++;
        $display("FAIL pulse_match: got kind=%0d cycle=%0d, expected kind=%0d cycle=%0d",
                 kind, cyc, e.kind, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (btn_rise || btn_fall) begin
      check_eq("rise_fall_exclusive", int'(btn_rise && btn_fall), 0);
    end
    if (btn_rise) begin
      pop_check(0);
      check_eq("level_on_rise", int'(btn_level), 1);
    end
    if (btn_fall) begin
      pop_check(1);
      check_eq("level_on_fall", int'(btn_level), 0);
    end
    if (long_press) pop_check(2);
  end

  initial begin
    int pat[4];
    int r;
    pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 0;
    reset  = 1'b1;
    btn_in = 1'b0;
    tick(3);
    check_outputs_zero("reset");
    check_eq("reset_state", int'(dut.state_q), int'(STABLE_LO));
    reset = 1'b0;
    tick(2);

    // Clean press: pulse lands exactly 7 edges after the drive, not before.
    btn_in = 1'b1;
    push_ev(0, cyc + 7);
    tick(6);
    check_eq("press_not_early", int'(btn_level), 0);
    tick(1);
    check_eq("press_level", int'(btn_level), 1);
    tick(14);

    // Release.
    btn_in = 1'b0;
    push_ev(1, cyc + 7);
    tick(6);
    check_eq("release_not_early", int'(btn_level), 1);
    tick(1);
    check_eq("release_level", int'(btn_level), 0);
    tick(10);

    // Bounce, then settle high.
    for (int i = 0; i < 4; i++) begin
      btn_in = pat[i][0];
      tick(1);
    end
    btn_in = 1'b1;
    push_ev(0, cyc + 7);
    tick(15);
    check_eq("bounce_level", int'(btn_level), 1);
    btn_in = 1'b0;
    push_ev(1, cyc + 7);
    tick(12);

    // Short glitch: three cycles high never qualifies.
    btn_in = 1'b1;
    tick(3);
    btn_in = 1'b0;
    tick(10);
    check_eq("glitch_level", int'(btn_level), 0);
    check_eq("glitch_state", int'(dut.state_q), int'(STABLE_LO));

    // Reset in the middle of PEND_HI with the button held.
    btn_in = 1'b1;
    tick(4);
    check_eq("pend_state", int'(dut.state_q), int'(PEND_HI));
    reset = 1'b1;
    tick(1);
    check_outputs_zero("midreset1");
    tick(1);
    check_outputs_zero("midreset2");
    reset = 1'b0;
    push_ev(0, cyc + 7);
    tick(15);
    btn_in = 1'b0;
    push_ev(1, cyc + 7);
    tick(12);

    // Long hold: long pulse 20 cycles after the rise when enabled.
    btn_in = 1'b1;
    r = cyc + 7;
    push_ev(0, r);
`ifdef BUTTON_LONG_PRESS_EN
    push_ev(2, r + 20);
`endif
    tick(40);
    btn_in = 1'b0;
    push_ev(1, cyc + 7);
    tick(12);

    check_eq("pending_events", exp_q.size(), 0);
    check_outputs_zero("idle_end");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 100000, meaning the number of consecutive stable synchronized samples required to accept a new level (1 ms at 100 MHz); legal values are 2 or more.
REQ-002 The module SHALL have parameter ACTIVE_LOW, default 0; when set to 1 the pad is inverted before synchronization, so a pressed button reads as 1 internally.
REQ-003 The module SHALL have parameter LONG_CYCLES, default 100000000, meaning the stable-pressed duration (in clk cycles) for the long-press pulse; it is only used when REQ-019 applies.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port btn_in, input, 1 bit: raw asynchronous button/switch pad.
REQ-007 The module SHALL have port btn_level, output, 1 bit: debounced, active-high pressed level.
REQ-008 The module SHALL have port btn_rise, output, 1 bit: one-cycle pulse on an accepted press.
REQ-009 The module SHALL have port btn_fall, output, 1 bit: one-cycle pulse on an accepted release.
REQ-010 The module SHALL have port long_press, output, 1 bit: one-cycle pulse on the long-press threshold.

Function
REQ-011 btn_in (after optional inversion) SHALL pass through exactly 2 flip-flops; the FSM sees only the second stage (sync).
REQ-012 The FSM SHALL have exactly the states STABLE_LO, PEND_HI, STABLE_HI and PEND_LO.
REQ-013 In STABLE_LO, sync=1 SHALL move the FSM to PEND_HI with cnt=0; in STABLE_HI, sync=0 SHALL move it to PEND_LO with cnt=0; otherwise the FSM SHALL hold.
REQ-014 In PEND_HI/PEND_LO, sync reverting to the old level SHALL return the FSM to the prior STABLE state (glitch rejected, no pulse, btn_level unchanged).
REQ-015 In PEND_HI/PEND_LO, while sync holds, cnt SHALL increment; on the edge where cnt==DEBOUNCE_CYCLES-1, the FSM SHALL enter the new STABLE state, btn_level SHALL take the new value and btn_rise/btn_fall SHALL pulse high for exactly that one cycle.
REQ-016 Latency: with btn_in changing before edge 1 and then stable, btn_level and its pulse SHALL be visible after edge DEBOUNCE_CYCLES+3, and never earlier.
REQ-017 cnt SHALL be $clog2(DEBOUNCE_CYCLES) bits wide and SHALL never wrap; it is cleared on every PEND entry.
REQ-018 btn_rise and btn_fall SHALL never be high in the same cycle, and SHALL never pulse twice without an intervening pulse of the opposite edge.

Configuration
REQ-019 With BUTTON_LONG_PRESS_EN defined, a second counter (width $clog2(LONG_CYCLES+1)) SHALL clear on entry to STABLE_HI and increment while in STABLE_HI (including PEND_LO), saturating at LONG_CYCLES.
REQ-020 With BUTTON_LONG_PRESS_EN defined, long_press SHALL pulse once, on the cycle the counter first reaches LONG_CYCLES, at most once per press, and the counter SHALL clear on return to STABLE_LO.
REQ-021 Without BUTTON_LONG_PRESS_EN, the port SHALL remain and long_press SHALL be tied to 0, with no long-press counter logic synthesized.

Reset
REQ-022 On reset=1 at a clk edge, the sync flops SHALL load 0 (the post-inversion inactive level) and the FSM SHALL enter STABLE_LO.
REQ-023 On reset, cnt and the long-press counter SHALL clear to 0, and btn_level, btn_rise, btn_fall and long_press SHALL all be 0 the following cycle.
REQ-024 Reset mid-PEND SHALL discard the pending transition.
REQ-025 If the pad is held pressed through reset, exactly one btn_rise SHALL follow release of reset, after the full REQ-016 latency.

Structure
REQ-026 Package button_pkg SHALL hold the FSM state enum typedef (btn_state_t) and the default constants DEBOUNCE_CYCLES_DEF and LONG_CYCLES_DEF.
REQ-027 Sub-module sync_2ff (1-bit, reset value parameterized) SHALL implement REQ-011, and button_debounce SHALL instantiate it once.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-028 Clean press: btn_in 0->1 held 20 cycles -> btn_level=1 and btn_rise=1 for one cycle after edge 7; btn_fall=0 throughout.
REQ-029 Bounce: btn_in toggles 1,0,1,0 each cycle then settles at 1 -> exactly one btn_rise, 7 edges after the final 0->1, with no pulse earlier.
REQ-030 Short glitch: btn_in high for 3 cycles then 0 -> btn_level stays 0, no pulses, and the FSM is back in STABLE_LO.
REQ-031 Release: from STABLE_HI, btn_in 1->0 held -> btn_fall one cycle after edge 7, btn_level=0.
REQ-032 Reset mid-operation: reset asserted in PEND_HI with btn_in held 1, released after 2 cycles -> all outputs 0 during reset, then a single btn_rise 7 edges after release.
REQ-033 Long press (macro defined): btn_in held 1 for 40 cycles -> one long_press pulse 20 cycles after btn_rise and no second pulse; with the macro undefined, long_press=0 throughout.
